// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
//   Shared board constants and types for the button input stage.
//   CLK_HZ / DEBOUNCE_MS give the default debounce length in CLK cycles.
//   Ports: none (package).
package button_conditioner_pkg;

  localparam int CLK_HZ      = 12_000_000;
  localparam int DEBOUNCE_MS = 5;

  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEFAULT = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

  // Registered per-channel outputs; "rel" because release is a keyword.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic toggle;
  } chan_out_t;

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the raw button inputs and the conditioned outputs of all channels.
//   BTN_IN      : raw buttons, active-high, asynchronous to CLK
//   BTN_LEVEL   : debounced level
//   BTN_PRESS   : one-cycle strobe on accepted 0->1
//   BTN_RELEASE : one-cycle strobe on accepted 1->0
//   BTN_TOGGLE  : inverts on every accepted press
//   master = board/harness side (drives BTN_IN), slave = conditioner.
interface button_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] BTN_IN;
  logic [N_BTN-1:0] BTN_LEVEL;
  logic [N_BTN-1:0] BTN_PRESS;
  logic [N_BTN-1:0] BTN_RELEASE;
  logic [N_BTN-1:0] BTN_TOGGLE;

  modport master (
    output BTN_IN,
    input  BTN_LEVEL,
    input  BTN_PRESS,
    input  BTN_RELEASE,
    input  BTN_TOGGLE
  );

  modport slave (
    input  BTN_IN,
    output BTN_LEVEL,
    output BTN_PRESS,
    output BTN_RELEASE,
    output BTN_TOGGLE
  );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// debounce_channel
//   One button: two-flop synchroniser, debounce counter, press/release
//   strobes and toggle latch. All outputs registered.
//   CLK         : clock
//   RST_N       : synchronous active-low reset
//   BTN_IN      : raw button (asynchronous)
//   BTN_LEVEL   : debounced level
//   BTN_PRESS   : one-cycle strobe on accepted press
//   BTN_RELEASE : one-cycle strobe on accepted release
//   BTN_TOGGLE  : inverts on every accepted press
//
//   state      | meaning
//   ST_STABLE  | synchronised input equals BTN_LEVEL, counter held at 0
//   ST_PENDING | synchronised input differs, counting toward acceptance
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE,
  output logic BTN_TOGGLE
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  chan_out_t            out_q;
  chan_out_t            out_d;
  deb_state_t           state;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      s1    <= BTN_IN;
      s2    <= s1;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  // The state is implied by comparing the synchronised input with the
  // accepted level, so any single matching cycle falls back to STABLE.
  always_comb begin
    state      = (s2 != out_q.level) ? ST_PENDING : ST_STABLE;
    cnt_d      = '0;
    out_d      = out_q;
    out_d.press = 1'b0;
    out_d.rel   = 1'b0;
    case (state)
      ST_STABLE: cnt_d = '0;
      ST_PENDING: begin
        if (cnt_q == CNT_LAST) begin
          out_d.level = s2;
          out_d.press = s2;
          out_d.rel   = ~s2;
          if (s2) begin
            out_d.toggle = ~out_q.toggle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    BTN_LEVEL   = out_q.level;
    BTN_PRESS   = out_q.press;
    BTN_RELEASE = out_q.rel;
    BTN_TOGGLE  = out_q.toggle;
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   N_BTN independent debounce channels between the raw board buttons and
//   the gate test harnesses.
//   CLK   : board clock
//   RST_N : synchronous active-low reset
//   btn   : button_conditioner_if.slave (BTN_IN in; LEVEL/PRESS/RELEASE/TOGGLE out)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  button_conditioner_if.slave   btn
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] toggle_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_chan (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .BTN_IN      (btn.BTN_IN[i]),
      .BTN_LEVEL   (level_w[i]),
      .BTN_PRESS   (press_w[i]),
      .BTN_RELEASE (release_w[i]),
      .BTN_TOGGLE  (toggle_w[i])
    );
  end

  assign btn.BTN_LEVEL   = level_w;
  assign btn.BTN_PRESS   = press_w;
  assign btn.BTN_RELEASE = release_w;
  assign btn.BTN_TOGGLE  = toggle_w;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed test-plan steps followed by randomized button activity, checked
//   each cycle against a window-based reference model.
module tb_button_conditioner;

  localparam int N = 3;
  localparam int D = 8;

  logic CLK;
  logic RST_N;

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .btn   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reference model: the synchronised input is a two-sample delay of BTN_IN;
  // a channel accepts a change once the last D pre-edge samples since the
  // previous event all disagreed with the accepted level.
  bit [N-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl, m_tg;
  bit         win [N][$];
  bit         sb_en = 1'b0;
  int         press_cnt [N];
  int         rel_cnt   [N];
  bit [N-1:0] lvl_seen;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pr = '0; m_rl = '0; m_tg = '0;
        for (int i = 0; i < N; i++) win[i].delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          bit pre;
          bit all_set;
          pre     = m_s2[i];
          m_s2[i] = m_s1[i];
          m_s1[i] = bus.BTN_IN[i];
          m_pr[i] = 1'b0;
          m_rl[i] = 1'b0;
          win[i].push_back(pre != m_lvl[i]);
          if (win[i].size() > D) void'(win[i].pop_front());
          all_set = (win[i].size() == D);
          for (int k = 0; k < win[i].size(); k++) if (!win[i][k]) all_set = 1'b0;
          if (all_set) begin
            m_lvl[i] = pre;
            m_pr[i]  = pre;
            m_rl[i]  = ~pre;
            if (pre) m_tg[i] = ~m_tg[i];
            win[i].delete();
          end
        end
      end
      if (sb_en) begin
        check("sb_level",   32'(bus.BTN_LEVEL),   32'(m_lvl));
        check("sb_press",   32'(bus.BTN_PRESS),   32'(m_pr));
        check("sb_release", 32'(bus.BTN_RELEASE), 32'(m_rl));
        check("sb_toggle",  32'(bus.BTN_TOGGLE),  32'(m_tg));
        check("sb_excl",    32'(bus.BTN_PRESS & bus.BTN_RELEASE), 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (bus.BTN_PRESS[i] === 1'b1)   press_cnt[i]++;
        if (bus.BTN_RELEASE[i] === 1'b1) rel_cnt[i]++;
      end
      lvl_seen |= bus.BTN_LEVEL;
    end
  end

  initial begin
    bit [N-1:0] v;
    RST_N      = 1'b0;
    bus.BTN_IN = '0;
    tick(3);
    check("rst_level",   32'(bus.BTN_LEVEL),   32'd0);
    check("rst_press",   32'(bus.BTN_PRESS),   32'd0);
    check("rst_release", 32'(bus.BTN_RELEASE), 32'd0);
    check("rst_toggle",  32'(bus.BTN_TOGGLE),  32'd0);
    sb_en = 1'b1;
    RST_N = 1'b1;
    tick(4);

    // 1: clean press on channel 0
    bus.BTN_IN = 3'b001;
    tick(9);
    check("t1_level_early", 32'(bus.BTN_LEVEL), 32'd0);
    check("t1_press_early", 32'(bus.BTN_PRESS), 32'd0);
    tick(1);
    check("t1_level",  32'(bus.BTN_LEVEL),  32'b001);
    check("t1_press",  32'(bus.BTN_PRESS),  32'b001);
    check("t1_toggle", 32'(bus.BTN_TOGGLE), 32'b001);
    tick(1);
    check("t1_press_end", 32'(bus.BTN_PRESS), 32'd0);
    tick(9);
    check("t1_level_hold", 32'(bus.BTN_LEVEL), 32'b001);

    // 4: release and press again on channel 0
    rel_cnt[0] = 0;
    bus.BTN_IN = 3'b000;
    tick(9);
    check("t4_rel_early", 32'(bus.BTN_RELEASE), 32'd0);
    check("t4_lvl_early", 32'(bus.BTN_LEVEL),   32'b001);
    tick(1);
    check("t4_release", 32'(bus.BTN_RELEASE), 32'b001);
    check("t4_level",   32'(bus.BTN_LEVEL),   32'd0);
    check("t4_tog_keep", 32'(bus.BTN_TOGGLE), 32'b001);
    tick(1);
    check("t4_rel_end", 32'(bus.BTN_RELEASE), 32'd0);
    tick(5);
    check("t4_rel_count", 32'(rel_cnt[0]), 32'd1);
    bus.BTN_IN = 3'b001;
    tick(10);
    check("t4_press2",  32'(bus.BTN_PRESS),  32'b001);
    check("t4_toggle0", 32'(bus.BTN_TOGGLE), 32'd0);
    tick(10);
    bus.BTN_IN = 3'b000;
    tick(12);

    // 2: bounce on channel 1
    press_cnt[1] = 0;
    bus.BTN_IN = 3'b010; tick(3);
    bus.BTN_IN = 3'b000; tick(1);
    bus.BTN_IN = 3'b010;
    tick(9);
    check("t2_level_early", 32'(bus.BTN_LEVEL[1]), 32'd0);
    check("t2_no_strobe",   32'(press_cnt[1]),     32'd0);
    tick(1);
    check("t2_level", 32'(bus.BTN_LEVEL[1]), 32'd1);
    check("t2_press", 32'(bus.BTN_PRESS),    32'b010);
    tick(8);
    check("t2_press_count", 32'(press_cnt[1]), 32'd1);
    bus.BTN_IN = 3'b000;
    tick(12);

    // 3: 7-cycle pulse on channel 2 is rejected
    press_cnt[2] = 0;
    lvl_seen     = '0;
    bus.BTN_IN   = 3'b100;
    tick(7);
    bus.BTN_IN   = 3'b000;
    tick(15);
    check("t3_level_seen", 32'(lvl_seen[2]),       32'd0);
    check("t3_press",      32'(press_cnt[2]),      32'd0);
    check("t3_toggle",     32'(bus.BTN_TOGGLE[2]), 32'd0);

    // 5: reset while channel 0 counter is at 5
    bus.BTN_IN = 3'b001;
    tick(7);
    RST_N = 1'b0;
    tick(1);
    check("t5_rst_level",   32'(bus.BTN_LEVEL),   32'd0);
    check("t5_rst_press",   32'(bus.BTN_PRESS),   32'd0);
    check("t5_rst_release", 32'(bus.BTN_RELEASE), 32'd0);
    check("t5_rst_toggle",  32'(bus.BTN_TOGGLE),  32'd0);
    RST_N = 1'b1;
    tick(9);
    check("t5_level_early", 32'(bus.BTN_LEVEL), 32'd0);
    tick(1);
    check("t5_level",  32'(bus.BTN_LEVEL),  32'b001);
    check("t5_press",  32'(bus.BTN_PRESS),  32'b001);
    check("t5_toggle", 32'(bus.BTN_TOGGLE), 32'b001);
    bus.BTN_IN = 3'b000;
    tick(12);

    // 6: all channels together
    bus.BTN_IN = 3'b111;
    tick(9);
    check("t6_press_early", 32'(bus.BTN_PRESS), 32'd0);
    tick(1);
    check("t6_press", 32'(bus.BTN_PRESS), 32'b111);
    tick(1);
    check("t6_press_end", 32'(bus.BTN_PRESS), 32'd0);
    bus.BTN_IN = 3'b000;
    tick(12);

    // Random activity with occasional resets
    v = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) v[i] = ~v[i];
      end
      bus.BTN_IN = v;
      RST_N = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    RST_N = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
